// File: rtl/segment_transition_scheduler.sv
// Segment transition scheduler.
// Selects the sampler's active read segment. A request either applies at once
// (infinite repeat) or waits for a sync, time or GPIO condition. After the switch,
// the block counts loops and then stops, or alternates segments in EXT mode.
module segment_transition_scheduler #(
  parameter int TIME_WIDTH = 64,
  parameter int REP_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  UPDATE_SETTINGS,
  input  logic                  REQ_SEGMENT,
  input  logic [REP_WIDTH-1:0]  REP,
  input  logic [7:0]            TRANSITION_MODE,
  input  logic [TIME_WIDTH-1:0] TRANSITION_VALUE,
  input  logic [TIME_WIDTH-1:0] SYS_TIME,
  input  logic                  LOOP_END,
  input  logic [3:0]            GPIO_IN,
  output logic                  SEGMENT,
  output logic                  STOP,
  output logic                  PENDING,
  output logic                  ERR
);

  localparam logic [7:0] MODE_SYNC_IDX = 8'h00;
  localparam logic [7:0] MODE_SYS_TIME = 8'h01;
  localparam logic [7:0] MODE_GPIO     = 8'h02;
  localparam logic [7:0] MODE_EXT      = 8'hF0;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SYNC,
    WAIT_TIME,
    WAIT_GPIO,
    RUN_INF,
    RUN_FINITE,
    STOPPED
  } state_t;

  state_t                  state;
  logic                    seg_q;
  logic [REP_WIDTH-1:0]    rep_q;
  logic [TIME_WIDTH-1:0]   value_q;
  logic                    ext_q;
  logic [REP_WIDTH-1:0]    loop_cnt;
  logic [3:0]              gpio_q;

  logic                    rep_inf;
  logic                    mode_ok;
  state_t                  wait_state;
  logic [3:0]              gpio_rise;
  logic                    fire;

  // Decode the incoming request and evaluate the pending transition condition.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    mode_ok    = 1'b1;
    wait_state = WAIT_SYNC;
    fire       = 1'b0;
    rep_inf    = &REP;
    gpio_rise  = GPIO_IN & ~gpio_q;

    case (TRANSITION_MODE)
      MODE_SYNC_IDX, MODE_EXT: wait_state = WAIT_SYNC;
      MODE_SYS_TIME:           wait_state = WAIT_TIME;
      MODE_GPIO:               wait_state = WAIT_GPIO;
      default:                 mode_ok    = 1'b0;
    endcase

    case (state)
      WAIT_SYNC: fire = LOOP_END;
      WAIT_TIME: fire = (SYS_TIME >= value_q);
      WAIT_GPIO: fire = gpio_rise[value_q[1:0]];
      default:   fire = 1'b0;
    endcase
  end

  // Scheduler FSM with registered outputs; a request strobe always takes priority over LOOP_END.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      // NOTE: the latched request and GPIO history are plain flops, so they are cleared with everything else.
      state    <= IDLE;
      SEGMENT  <= 1'b0;
      STOP     <= 1'b0;
      PENDING  <= 1'b0;
      ERR      <= 1'b0;
      seg_q    <= 1'b0;
      rep_q    <= '0;
      value_q  <= '0;
      ext_q    <= 1'b0;
      loop_cnt <= '0;
      gpio_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      gpio_q <= GPIO_IN;
      if (UPDATE_SETTINGS) begin
        if (rep_inf) begin
          SEGMENT <= REQ_SEGMENT;
          STOP    <= 1'b0;
          PENDING <= 1'b0;
          ERR     <= 1'b0;
          state   <= RUN_INF;
        end else if (mode_ok) begin
          seg_q   <= REQ_SEGMENT;
          rep_q   <= REP;
          value_q <= TRANSITION_VALUE;
          ext_q   <= (TRANSITION_MODE == MODE_EXT);
          PENDING <= 1'b1;
          ERR     <= 1'b0;
          state   <= wait_state;
        end else begin
          ERR <= 1'b1;
        end
      end else begin
        case (state)
          WAIT_SYNC, WAIT_TIME, WAIT_GPIO: begin
            if (fire) begin
              SEGMENT  <= seg_q;
              PENDING  <= 1'b0;
              STOP     <= 1'b0;
              loop_cnt <= '0;
              state    <= RUN_FINITE;
            end
          end
          RUN_FINITE: begin
            if (LOOP_END) begin
              if (loop_cnt == rep_q) begin
                if (ext_q) begin
                  SEGMENT  <= ~SEGMENT;
                  loop_cnt <= '0;
                end else begin
                  STOP  <= 1'b1;
                  state <= STOPPED;
                end
              end else begin
                loop_cnt <= loop_cnt + REP_WIDTH'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_segment_transition_scheduler.sv
// Testbench for segment_transition_scheduler.
// The driver applies one input vector per cycle and pushes the expected outputs from
// a behavioural model. The monitor pops and compares those outputs after every rising edge.
module tb_segment_transition_scheduler;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        UPDATE_SETTINGS = 1'b0;
  logic        REQ_SEGMENT = 1'b0;
  logic [15:0] REP = '0;
  logic [7:0]  TRANSITION_MODE = '0;
  logic [63:0] TRANSITION_VALUE = '0;
  logic [63:0] SYS_TIME = '0;
  logic        LOOP_END = 1'b0;
  logic [3:0]  GPIO_IN = '0;
  logic        SEGMENT, STOP, PENDING, ERR;

  segment_transition_scheduler #(.TIME_WIDTH(64), .REP_WIDTH(16)) dut (
    .CLK(CLK), .RESETN(RESETN), .UPDATE_SETTINGS(UPDATE_SETTINGS),
    .REQ_SEGMENT(REQ_SEGMENT), .REP(REP), .TRANSITION_MODE(TRANSITION_MODE),
    .TRANSITION_VALUE(TRANSITION_VALUE), .SYS_TIME(SYS_TIME), .LOOP_END(LOOP_END),
    .GPIO_IN(GPIO_IN), .SEGMENT(SEGMENT), .STOP(STOP), .PENDING(PENDING), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [3:0] exp_q[$];

  // Stimulus staging: set these, then call tick().
  logic        rn = 1'b0, u = 1'b0, rs = 1'b0, le = 1'b0;
  logic [15:0] rp = '0;
  logic [7:0]  md = '0;
  logic [63:0] tv = '0, st = 64'd100;
  logic [3:0]  gp = '0;

  // Reference model: a request record, plus "loops still to run" in the current segment.
  logic        m_seg, m_stop, m_pend, m_err;
  logic        m_has_req, r_seg;
  logic [15:0] r_rep;
  logic [7:0]  r_mode;
  logic [63:0] r_val;
  logic        m_finite, m_ext;
  longint      m_left, m_run_loops;
  logic [3:0]  m_gprev;

  task automatic model_step();
    logic hit;
    logic [3:0] rise;
    if (!rn) begin
      m_seg = 0; m_stop = 0; m_pend = 0; m_err = 0;
      m_has_req = 0; m_finite = 0; m_gprev = '0;
      return;
    end
    rise = gp & ~m_gprev;
    if (u) begin
      if (rp == 16'hFFFF) begin
        m_seg = rs; m_stop = 0; m_pend = 0; m_err = 0;
        m_has_req = 0; m_finite = 0;
      end else if (md == 8'h00 || md == 8'h01 || md == 8'h02 || md == 8'hF0) begin
        m_has_req = 1; r_seg = rs; r_rep = rp; r_mode = md; r_val = tv;
        m_pend = 1; m_err = 0; m_finite = 0;
      end else begin
        m_err = 1;
      end
    end else if (m_has_req) begin
      case (r_mode)
        8'h01:   hit = (st >= r_val);
        8'h02:   hit = rise[r_val[1:0]];
        default: hit = le;
      endcase
      if (hit) begin
        m_seg = r_seg; m_pend = 0; m_stop = 0; m_has_req = 0;
        m_finite = 1; m_ext = (r_mode == 8'hF0);
        m_run_loops = longint'(r_rep) + 1;
        m_left = m_run_loops;
      end
    end else if (m_finite && le) begin
      m_left--;
      if (m_left == 0) begin
        if (m_ext) begin
          m_seg = ~m_seg;
          m_left = m_run_loops;
        end else begin
          m_stop = 1;
          m_finite = 0;
        end
      end
    end
    m_gprev = gp;
  endtask

  // Apply one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic tick();
    @(negedge CLK);
    RESETN = rn; UPDATE_SETTINGS = u; REQ_SEGMENT = rs; REP = rp;
    TRANSITION_MODE = md; TRANSITION_VALUE = tv; SYS_TIME = st;
    LOOP_END = le; GPIO_IN = gp;
    model_step();
    exp_q.push_back({m_seg, m_stop, m_pend, m_err});
    u = 0; le = 0; st = st + 64'd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic req(input logic s, input logic [15:0] r, input logic [7:0] m, input logic [63:0] v);
    u = 1; rs = s; rp = r; md = m; tv = v;
    tick();
  endtask

  task automatic pulse_loop_end();
    le = 1;
    tick();
    idle(1);
  endtask

  task automatic check(input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL outputs cycle %0d: got seg=%b stop=%b pend=%b err=%b, exp seg=%b stop=%b pend=%b err=%b",
               cyc, got[3], got[2], got[1], got[0], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Monitor: compare the DUT outputs against the queued expectation after each edge.
  always @(posedge CLK) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) check({SEGMENT, STOP, PENDING, ERR}, exp_q.pop_front());
  end

  initial begin
    logic [7:0] modes [6];
    modes = '{8'h00, 8'h01, 8'h02, 8'hF0, 8'h05, 8'h33};

    // Reset state.
    rn = 0; idle(2);
    rn = 1; idle(2);

    // Infinite repeat applies immediately.
    req(1'b1, 16'hFFFF, 8'h00, 64'd0);
    idle(2);

    // SYNC_IDX with REP=2: switch on pulse 1, stop on pulse 4.
    req(1'b0, 16'hFFFF, 8'h00, 64'd0);
    req(1'b1, 16'd2, 8'h00, 64'd0);
    idle(2);
    for (int i = 0; i < 4; i++) pulse_loop_end();
    pulse_loop_end();

    // SYS_TIME: target 1000 with time ramping from 990.
    st = 64'd990;
    req(1'b0, 16'd0, 8'h01, 64'd1000);
    idle(14);

    // SYS_TIME target already in the past.
    req(1'b1, 16'd1, 8'h01, 64'd5);
    idle(2);

    // GPIO pin 2 already high: no switch until a fresh rising edge.
    gp = 4'b0100; idle(2);
    req(1'b0, 16'd1, 8'h02, 64'd2);
    idle(4);
    gp = 4'b0000; idle(2);
    gp = 4'b0100; idle(3);

    // EXT with REP=0: segment alternates 1,0,1 and STOP stays low.
    req(1'b0, 16'hFFFF, 8'h00, 64'd0);
    req(1'b1, 16'd0, 8'hF0, 64'd0);
    idle(1);
    for (int i = 0; i < 3; i++) pulse_loop_end();

    // Unsupported mode sets ERR and leaves everything else untouched.
    req(1'b0, 16'd3, 8'h05, 64'd0);
    idle(2);
    pulse_loop_end();

    // Request and LOOP_END together: the LOOP_END is not a sync event.
    le = 1;
    req(1'b0, 16'd1, 8'h00, 64'd0);
    idle(2);
    pulse_loop_end();

    // Reset during WAIT_TIME discards the request.
    req(1'b1, 16'd1, 8'h01, st + 64'd20);
    idle(3);
    rn = 0; idle(1);
    rn = 1; idle(30);

    // Request honoured on the first edge after reset release.
    rn = 0; idle(1);
    rn = 1;
    req(1'b1, 16'hFFFF, 8'h02, 64'd0);
    idle(1);

    // Randomised traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      rn = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 99) < 8) begin
        u  = 1;
        rs = 1'($urandom_range(0, 1));
        rp = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
        md = modes[$urandom_range(0, 5)];
        if (md == 8'h01) tv = st + 64'($urandom_range(0, 40)) - 64'd8;
        else tv = {$urandom, $urandom};
      end
      le = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 3) == 0) gp[$urandom_range(0, 3)] = ~gp[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) gp = 4'($urandom);
      st = st + 64'($urandom_range(0, 2));
      tick();
    end
    rn = 1;
    idle(2);

    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/segment_transition_scheduler.md
SEGMENT_TRANSITION_SCHEDULER -- requirements
Module: segment_transition_scheduler

Interface
REQ-001 The block SHALL have parameter TIME_WIDTH, default 64, the width of the system-time and transition-value fields.
REQ-002 The block SHALL have parameter REP_WIDTH, default 16, the width of the repeat count.
REQ-003 The block SHALL have one clock, input CLK, width 1, on whose rising edge all state updates.
REQ-004 The block SHALL have input RESETN, width 1: asynchronous, active-low reset.
REQ-005 The block SHALL have input UPDATE_SETTINGS, width 1: one-cycle request strobe that latches REQ_SEGMENT, REP, TRANSITION_MODE and TRANSITION_VALUE.
REQ-006 The block SHALL have input REQ_SEGMENT, width 1: requested read segment (0/1).
REQ-007 The block SHALL have input REP, width REP_WIDTH: loop count minus 1; all-ones means infinite.
REQ-008 The block SHALL have input TRANSITION_MODE, width 8, taking values 0x00 SYNC_IDX, 0x01 SYS_TIME, 0x02 GPIO or 0xF0 EXT.
REQ-009 The block SHALL have input TRANSITION_VALUE, width TIME_WIDTH: target time (SYS_TIME mode) or GPIO pin index in bits [1:0] (GPIO mode).
REQ-010 The block SHALL have input SYS_TIME, width TIME_WIDTH: free-running system time, monotonic.
REQ-011 The block SHALL have input LOOP_END, width 1: one-cycle pulse from the sampler when the active segment's last index is consumed.
REQ-012 The block SHALL have input GPIO_IN, width 4: inputs that are already synchronised.
REQ-013 The block SHALL have output SEGMENT, width 1: active read segment, registered.
REQ-014 The block SHALL have output STOP, width 1: finite repeat exhausted; the sampler holds its last index.
REQ-015 The block SHALL have output PENDING, width 1: a request is latched and is waiting for its transition condition.
REQ-016 The block SHALL have output ERR, width 1: the last request carried an unsupported TRANSITION_MODE.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, WAIT_SYNC, WAIT_TIME, WAIT_GPIO, RUN_INF, RUN_FINITE, STOPPED.
REQ-018 On an UPDATE_SETTINGS request with REP = all-ones, the block SHALL apply the segment immediately: SEGMENT <= REQ_SEGMENT, STOP <= 0, state RUN_INF, with TRANSITION_MODE ignored.
REQ-019 On an UPDATE_SETTINGS request with finite REP, the block SHALL latch the request, set PENDING=1, clear ERR, and enter WAIT_SYNC for SYNC_IDX or EXT, WAIT_TIME for SYS_TIME, or WAIT_GPIO for GPIO.
REQ-020 On an UPDATE_SETTINGS request with finite REP and any other TRANSITION_MODE, the block SHALL ignore the request, set ERR=1, and leave the state, SEGMENT and STOP unchanged.
REQ-021 In WAIT_SYNC, a sampled LOOP_END SHALL cause SEGMENT to switch on the next edge, along with PENDING=0, STOP=0, loop counter=0 and state RUN_FINITE.
REQ-022 In WAIT_TIME, sampled SYS_TIME >= latched value (unsigned) SHALL cause the same switch; a value already in the past SHALL switch on the first cycle in WAIT_TIME.
REQ-023 In WAIT_GPIO, a rising edge of GPIO_IN[value[1:0]] SHALL cause the same switch; the edge is detected against a registered copy of GPIO_IN, and a level already high on entry SHALL NOT trigger.
REQ-024 In RUN_FINITE, each LOOP_END SHALL increment the REP_WIDTH-bit loop counter.
REQ-025 In RUN_FINITE, on the LOOP_END where counter == latched REP (i.e. REP+1 loops completed), non-EXT mode SHALL set STOP=1 and enter STOPPED, with SEGMENT unchanged.
REQ-026 In RUN_FINITE, on that same LOOP_END in EXT mode, SEGMENT SHALL toggle, the counter SHALL clear, and the state SHALL stay RUN_FINITE, alternating segments indefinitely.
REQ-027 In RUN_INF and STOPPED, LOOP_END SHALL be ignored.
REQ-028 If UPDATE_SETTINGS and LOOP_END occur in the same cycle, UPDATE_SETTINGS SHALL win: the LOOP_END is neither counted nor used as a sync event.
REQ-029 A new UPDATE_SETTINGS in any WAIT_* state SHALL replace the pending request, with no switch for the old one.
REQ-030 A new UPDATE_SETTINGS in RUN_* or STOPPED SHALL be handled per REQ-018 to REQ-020, with STOP holding its value until the new switch occurs.
REQ-031 A requested segment equal to the current one SHALL still perform the full transition sequence, restarting the loop counter.
REQ-032 The block SHALL NOT wrap the loop counter at REP = all-ones-minus-1; the counter reaches REP before overflow is possible.
REQ-033 All outputs SHALL be registered, with latency of one CLK from the triggering sampled event to the SEGMENT, STOP or PENDING change.

Reset
REQ-034 When RESETN is low, the block SHALL asynchronously force SEGMENT=0, STOP=0, PENDING=0, ERR=0, state IDLE, and clear the loop counter, latched request and GPIO history.
REQ-035 In IDLE, the block SHALL behave as RUN_INF on segment 0.
REQ-036 When RESETN is asserted mid-wait or mid-run, the pending request SHALL be discarded, with no switch after release.
REQ-037 After RESETN is released, the first UPDATE_SETTINGS SHALL be honoured on the first active edge.

Verification
REQ-038 The bench SHALL cover: after reset, UPDATE_SETTINGS with seg=1, REP=0xFFFF -> SEGMENT=1 one cycle later, STOP=0, PENDING=0.
REQ-039 The bench SHALL cover: seg=1, REP=2, SYNC_IDX, then 4 LOOP_END pulses -> switch after pulse 1, and STOP=1 after pulse 4 (3 loops on seg 1).
REQ-040 The bench SHALL cover: SYS_TIME mode with value=1000 and SYS_TIME ramping from 990 -> PENDING=1 until SYS_TIME=1000 is sampled, then SEGMENT switches on the next edge.
REQ-041 The bench SHALL cover: GPIO mode with value=2 and GPIO_IN[2] high before the request -> no switch; after a low->high edge, the switch happens one cycle later.
REQ-042 The bench SHALL cover: EXT mode with REP=0 and 3 LOOP_END pulses -> SEGMENT reads 1,0,1 after each pulse and STOP stays 0.
REQ-043 The bench SHALL cover: mode=0x05 with REP=3 -> ERR=1 and no state change; then UPDATE_SETTINGS and LOOP_END in the same cycle -> the LOOP_END is ignored; then RESETN pulsed during WAIT_TIME -> all outputs 0 and no later switch.
